// File: rtl/width_packer_if.sv
// Beat-in / word-out bundle for width_packer, plus its status outputs.
// slave is the packer's view, master is the driver/sink view.
interface width_packer_if #(
   parameter int IN_W  = 8,
   parameter int RATIO = 4
);
   localparam int OUT_W  = IN_W * RATIO;
   localparam int LANE_W = $clog2(RATIO + 1);

   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              in_sof;
   logic              in_ready;
   logic              flush;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic [LANE_W-1:0] out_lanes;
   logic              out_ready;
   logic              overflow;
   logic              misalign;
   logic [15:0]       word_cnt;

   modport slave (
      input  in_valid, in_data, in_sof, flush, out_ready,
      output in_ready, out_valid, out_data, out_lanes, overflow, misalign, word_cnt
   );

   modport master (
      output in_valid, in_data, in_sof, flush, out_ready,
      input  in_ready, out_valid, out_data, out_lanes, overflow, misalign, word_cnt
   );
endinterface

// File: rtl/width_packer.sv
// Packs RATIO IN_W-bit beats into one output word, with frame-start realignment,
// partial-word flush and sticky overflow/misalign status.
//
// state    | meaning
// OUT_IDLE | output register empty, out_valid low
// OUT_HELD | output register holds a word waiting for out_ready
module width_packer #(
   parameter int             IN_W      = 8,
   parameter int             RATIO     = 4,
   parameter bit             MSB_FIRST = 1'b1,
   parameter logic [IN_W-1:0] PAD      = '0
) (
   input logic         div_8_clk,
   input logic         rst_n,
   width_packer_if.slave bus
);
   localparam int OUT_W  = IN_W * RATIO;
   localparam int LANE_W = $clog2(RATIO + 1);
   localparam int CNT_W  = $clog2(RATIO);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

   typedef enum logic {OUT_IDLE, OUT_HELD} out_state_t;

   out_state_t        state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [OUT_W-1:0]  acc, acc_next, acc_beat, word;
   logic              flush_pend, flush_pend_next;
   logic [OUT_W-1:0]  out_data_q, out_data_next;
   logic [LANE_W-1:0] out_lanes_q, out_lanes_next;
   logic              overflow_q, misalign_q;
   logic [15:0]       word_cnt_q;

   logic              slot_free, realign, accept, completing, flush_req, emit, handshake;
   logic [CNT_W-1:0]  lane;
   logic [LANE_W-1:0] fill;

   function automatic int lane_lo(input int k);
      return MSB_FIRST ? OUT_W - (k + 1) * IN_W : k * IN_W;
   endfunction

   assign handshake  = (state == OUT_HELD) && bus.out_ready;
   assign slot_free  = (state == OUT_IDLE) || bus.out_ready;
   assign realign    = bus.in_sof && (cnt != '0);
   // Only a beat that would finish a word or throw one away needs the output slot.
   assign bus.in_ready = slot_free || ((cnt != LAST_LANE) && !realign);
   assign accept     = bus.in_valid && bus.in_ready;
   assign lane       = bus.in_sof ? '0 : cnt;
   assign completing = accept && (lane == LAST_LANE);
   assign flush_req  = bus.flush || flush_pend;

   always_comb begin
      state_next      = state;
      cnt_next        = cnt;
      acc_beat        = acc;
      acc_next        = acc;
      word            = '0;
      fill            = LANE_W'(cnt);
      emit            = 1'b0;
      flush_pend_next = flush_pend;
      out_data_next   = out_data_q;
      out_lanes_next  = out_lanes_q;

      if (accept) begin
         if (realign) begin
            acc_beat = '0;
         end
         for (int k = 0; k < RATIO; k++) begin
            if (lane == CNT_W'(k)) begin
               acc_beat[lane_lo(k) +: IN_W] = bus.in_data;
            end
         end
         fill = LANE_W'(lane) + LANE_W'(1);
      end

      // A completing beat always wins; a simultaneous flush then has nothing left.
      emit = completing || (flush_req && slot_free && (fill != '0));

      for (int k = 0; k < RATIO; k++) begin
         if (LANE_W'(k) < fill) begin
            word[lane_lo(k) +: IN_W] = acc_beat[lane_lo(k) +: IN_W];
         end else begin
            word[lane_lo(k) +: IN_W] = PAD;
         end
      end

      if (emit) begin
         cnt_next = '0;
         acc_next = '0;
      end else begin
         acc_next = acc_beat;
         if (accept) begin
            cnt_next = lane + CNT_W'(1);
         end
      end

      if (flush_req && slot_free) begin
         flush_pend_next = 1'b0;
      end else if (bus.flush) begin
         flush_pend_next = 1'b1;
      end

      if (emit) begin
         state_next     = OUT_HELD;
         out_data_next  = word;
         out_lanes_next = fill;
      end else if (handshake) begin
         state_next = OUT_IDLE;
      end
   end

   always_ff @(posedge div_8_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= OUT_IDLE;
         cnt         <= '0;
         acc         <= '0;
         flush_pend  <= 1'b0;
         out_data_q  <= '0;
         out_lanes_q <= '0;
         overflow_q  <= 1'b0;
         misalign_q  <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         acc         <= acc_next;
         flush_pend  <= flush_pend_next;
         out_data_q  <= out_data_next;
         out_lanes_q <= out_lanes_next;
         if (bus.in_valid && !bus.in_ready) begin
            overflow_q <= 1'b1;
         end
         if (accept && realign) begin
            misalign_q <= 1'b1;
         end
         if (handshake) begin
            word_cnt_q <= word_cnt_q + 16'd1;
         end
      end
   end

   assign bus.out_valid = (state == OUT_HELD);
   assign bus.out_data  = out_data_q;
   assign bus.out_lanes = out_lanes_q;
   assign bus.overflow  = overflow_q;
   assign bus.misalign  = misalign_q;
   assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_width_packer.sv
// Directed bench for width_packer: MSB-first instance "a" and LSB-first instance "b"
// share the same stimulus.
module tb_width_packer;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_sof;
   logic        flush;
   logic        out_ready;
   int          checks;
   int          failures;
   int          exp_wc;

   width_packer_if #(.IN_W(8), .RATIO(4)) if_a ();
   width_packer_if #(.IN_W(8), .RATIO(4)) if_b ();

   assign if_a.in_valid  = in_valid;
   assign if_a.in_data   = in_data;
   assign if_a.in_sof    = in_sof;
   assign if_a.flush     = flush;
   assign if_a.out_ready = out_ready;
   assign if_b.in_valid  = in_valid;
   assign if_b.in_data   = in_data;
   assign if_b.in_sof    = in_sof;
   assign if_b.flush     = flush;
   assign if_b.out_ready = out_ready;

   width_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .PAD(8'h00)) dut_a (
      .div_8_clk(clk), .rst_n(rst_n), .bus(if_a)
   );
   width_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b0), .PAD(8'h00)) dut_b (
      .div_8_clk(clk), .rst_n(rst_n), .bus(if_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send_beat(input logic [7:0] d, input logic sof);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = sof;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if (if_a.out_valid !== 1'b0 || if_a.out_data !== 32'h0 || if_a.out_lanes !== 3'd0) begin
         failures++;
         $display("FAIL reset_out valid=%b data=%h lanes=%0d expected 0/0/0", if_a.out_valid, if_a.out_data, if_a.out_lanes);
      end
      checks++;
      if (if_a.overflow !== 1'b0 || if_a.misalign !== 1'b0 || if_a.word_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_status ovf=%b mis=%b wc=%0d expected 0/0/0", if_a.overflow, if_a.misalign, if_a.word_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_wc = 0;
      idle_cycle();
   endtask

   task automatic test_msb_first();
      out_ready = 1'b1;
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b0);
      send_beat(8'h33, 1'b0);
      checks++;
      if (if_a.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL msb_early_valid got=%b expected 0", if_a.out_valid);
      end
      send_beat(8'h44, 1'b0);
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h11223344 || if_a.out_lanes !== 3'd4) begin
         failures++;
         $display("FAIL msb_word valid=%b data=%h lanes=%0d expected 1/11223344/4", if_a.out_valid, if_a.out_data, if_a.out_lanes);
      end
      checks++;
      if (if_b.out_data !== 32'h44332211) begin
         failures++;
         $display("FAIL lsb_word got=%h expected 44332211", if_b.out_data);
      end
      idle_cycle();
      exp_wc++;
      checks++;
      if (if_a.out_valid !== 1'b0 || if_a.word_cnt !== 16'(exp_wc)) begin
         failures++;
         $display("FAIL msb_after valid=%b wc=%0d expected 0/%0d", if_a.out_valid, if_a.word_cnt, exp_wc);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 8; i++) begin
         send_beat(8'(i), 1'b0);
         if (i == 4) begin
            checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h01020304) begin
               failures++;
               $display("FAIL b2b_first valid=%b data=%h expected 1/01020304", if_a.out_valid, if_a.out_data);
            end
         end
         if (i == 5) begin
            checks++;
            if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1) begin
               failures++;
               $display("FAIL b2b_gap valid=%b ready=%b expected 0/1", if_a.out_valid, if_a.in_ready);
            end
         end
      end
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h05060708 || if_b.out_data !== 32'h08070605) begin
         failures++;
         $display("FAIL b2b_second valid=%b a=%h b=%h expected 1/05060708/08070605", if_a.out_valid, if_a.out_data, if_b.out_data);
      end
      idle_cycle();
      exp_wc += 2;
      checks++;
      if (if_a.word_cnt !== 16'(exp_wc)) begin
         failures++;
         $display("FAIL b2b_wc got=%0d expected %0d", if_a.word_cnt, exp_wc);
      end
   endtask

   task automatic test_flush();
      send_beat(8'hAA, 1'b0);
      send_beat(8'hBB, 1'b0);
      flush = 1'b1;
      idle_cycle();
      flush = 1'b0;
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'hAABB0000 || if_a.out_lanes !== 3'd2) begin
         failures++;
         $display("FAIL flush_partial valid=%b data=%h lanes=%0d expected 1/aabb0000/2", if_a.out_valid, if_a.out_data, if_a.out_lanes);
      end
      checks++;
      if (if_b.out_data !== 32'h0000BBAA) begin
         failures++;
         $display("FAIL flush_lsb got=%h expected 0000bbaa", if_b.out_data);
      end
      idle_cycle();
      exp_wc++;
      flush = 1'b1;
      idle_cycle();
      flush = 1'b0;
      checks++;
      if (if_a.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_empty valid=%b expected 0", if_a.out_valid);
      end
      in_valid = 1'b1;
      in_data  = 8'h55;
      flush    = 1'b1;
      idle_cycle();
      in_valid = 1'b0;
      flush    = 1'b0;
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h55000000 || if_a.out_lanes !== 3'd1) begin
         failures++;
         $display("FAIL flush_with_beat valid=%b data=%h lanes=%0d expected 1/55000000/1", if_a.out_valid, if_a.out_data, if_a.out_lanes);
      end
      idle_cycle();
      exp_wc++;
      checks++;
      if (if_a.word_cnt !== 16'(exp_wc) || if_a.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_wc wc=%0d valid=%b expected %0d/0", if_a.word_cnt, if_a.out_valid, exp_wc);
      end
   endtask

   task automatic test_misalign();
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      send_beat(8'h03, 1'b1);
      checks++;
      if (if_a.misalign !== 1'b1 || if_a.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL misalign_flag mis=%b valid=%b expected 1/0", if_a.misalign, if_a.out_valid);
      end
      send_beat(8'h04, 1'b0);
      send_beat(8'h05, 1'b0);
      checks++;
      if (if_a.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL misalign_early valid=%b expected 0", if_a.out_valid);
      end
      send_beat(8'h06, 1'b0);
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h03040506 || if_a.out_lanes !== 3'd4) begin
         failures++;
         $display("FAIL misalign_word valid=%b data=%h lanes=%0d expected 1/03040506/4", if_a.out_valid, if_a.out_data, if_a.out_lanes);
      end
      idle_cycle();
      exp_wc++;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      send_beat(8'h21, 1'b0);
      send_beat(8'h22, 1'b0);
      send_beat(8'h23, 1'b0);
      send_beat(8'h24, 1'b0);
      send_beat(8'h31, 1'b0);
      send_beat(8'h32, 1'b0);
      send_beat(8'h33, 1'b0);
      checks++;
      if (if_a.overflow !== 1'b0 || if_a.out_data !== 32'h21222324) begin
         failures++;
         $display("FAIL ovf_pre ovf=%b data=%h expected 0/21222324", if_a.overflow, if_a.out_data);
      end
      in_valid = 1'b1;
      in_data  = 8'h34;
      #1;
      checks++;
      if (if_a.in_ready !== 1'b0) begin
         failures++;
         $display("FAIL ovf_ready_low got=%b expected 0", if_a.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (if_a.overflow !== 1'b1 || if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h21222324) begin
         failures++;
         $display("FAIL ovf_drop ovf=%b valid=%b data=%h expected 1/1/21222324", if_a.overflow, if_a.out_valid, if_a.out_data);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (if_a.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ovf_ready_release got=%b expected 1", if_a.in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_wc++;
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h31323334 || if_a.word_cnt !== 16'(exp_wc)) begin
         failures++;
         $display("FAIL ovf_next valid=%b data=%h wc=%0d expected 1/31323334/%0d", if_a.out_valid, if_a.out_data, if_a.word_cnt, exp_wc);
      end
      idle_cycle();
      exp_wc++;
      checks++;
      if (if_a.word_cnt !== 16'(exp_wc) || if_a.overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky wc=%0d ovf=%b expected %0d/1", if_a.word_cnt, if_a.overflow, exp_wc);
      end
   endtask

   task automatic test_reset_mid_word();
      out_ready = 1'b0;
      send_beat(8'h51, 1'b0);
      send_beat(8'h52, 1'b0);
      send_beat(8'h53, 1'b0);
      send_beat(8'h54, 1'b0);
      send_beat(8'h61, 1'b0);
      send_beat(8'h62, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (if_a.out_valid !== 1'b0 || if_a.out_data !== 32'h0 || if_a.out_lanes !== 3'd0 ||
          if_a.overflow !== 1'b0 || if_a.misalign !== 1'b0 || if_a.word_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_mid valid=%b data=%h lanes=%0d ovf=%b mis=%b wc=%0d expected all 0",
                  if_a.out_valid, if_a.out_data, if_a.out_lanes, if_a.overflow, if_a.misalign, if_a.word_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_wc = 0;
      out_ready = 1'b1;
      send_beat(8'h41, 1'b0);
      send_beat(8'h42, 1'b0);
      send_beat(8'h43, 1'b0);
      send_beat(8'h44, 1'b0);
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 32'h41424344) begin
         failures++;
         $display("FAIL reset_after valid=%b data=%h expected 1/41424344", if_a.out_valid, if_a.out_data);
      end
      idle_cycle();
      exp_wc++;
      checks++;
      if (if_a.word_cnt !== 16'(exp_wc)) begin
         failures++;
         $display("FAIL reset_after_wc got=%0d expected %0d", if_a.word_cnt, exp_wc);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_wc    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_sof    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_msb_first();
      test_back_to_back();
      test_flush();
      test_misalign();
      test_overflow();
      test_reset_mid_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
